// File: rtl/div_unit.sv
// div_unit: iterative 32-bit RV32M divider (DIV/DIVU/REM/REMU), restoring algorithm, one step per cycle.
// Latency: DONE 33 edges after accept; with DIV_EARLY_OUT_EN, divide-by-zero and signed overflow finish 1 edge after accept.
// Backpressure: START is sampled only in IDLE or FIN; START during RUN is ignored (no queuing). Optional macro: DIV_EARLY_OUT_EN.
module div_unit (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        START,
   input  logic [1:0]  OP,
   input  logic [31:0] DIVIDEND,
   input  logic [31:0] DIVISOR,
   output logic        BUSY,
   output logic        DONE,
   output logic [31:0] RESULT
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   logic [1:0]  r_state;
   logic [4:0]  r_cnt;
   logic [1:0]  r_op;
   logic [31:0] r_quo;      // dividend magnitude shifting out, quotient bits shifting in
   logic [32:0] r_rem;      // partial remainder
   logic [31:0] r_dsr;      // divisor magnitude
   logic [31:0] r_dvd_raw;  // original dividend, returned as remainder on divide-by-zero
   logic        r_neg_q;
   logic        r_neg_r;
   logic        r_div0;
   logic        r_ovf;
   logic [31:0] r_result;

   // Operand decode at accept: OP[0]=0 selects the signed variants.
   logic        w_signed;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic        w_div0;
   logic        w_ovf;
   logic        w_accept;

   assign w_signed = ~OP[0];
   assign w_a_neg  = w_signed & DIVIDEND[31];
   assign w_b_neg  = w_signed & DIVISOR[31];
   assign w_a_mag  = w_a_neg ? (-DIVIDEND) : DIVIDEND;
   assign w_b_mag  = w_b_neg ? (-DIVISOR) : DIVISOR;
   assign w_div0   = (DIVISOR == 32'h0000_0000);
   assign w_ovf    = w_signed && (DIVIDEND == 32'h8000_0000) && (DIVISOR == 32'hFFFF_FFFF);
   assign w_accept = START && ((r_state == S_IDLE) || (r_state == S_FIN));

   // One restoring step: shift in next dividend bit, trial-subtract, keep or restore.
   logic [32:0] w_shift;
   logic [32:0] w_trial;
   logic        w_qbit;
   logic [32:0] w_rem_nx;
   logic [31:0] w_quo_nx;
   logic [31:0] w_q_fix;
   logic [31:0] w_r_fix;
   logic [31:0] w_final;

   assign w_shift  = {r_rem[31:0], r_quo[31]};
   assign w_trial  = w_shift - {1'b0, r_dsr};
   assign w_qbit   = ~w_trial[32];
   assign w_rem_nx = w_qbit ? w_trial : w_shift;
   assign w_quo_nx = {r_quo[30:0], w_qbit};
   assign w_q_fix  = r_neg_q ? (-w_quo_nx) : w_quo_nx;
   assign w_r_fix  = r_neg_r ? (-w_rem_nx[31:0]) : w_rem_nx[31:0];

   // Final result select with divide-by-zero / overflow overrides taking precedence.
   always_comb begin
      w_final = r_op[1] ? w_r_fix : w_q_fix;
      if (r_div0) begin
         w_final = r_op[1] ? r_dvd_raw : 32'hFFFF_FFFF;
      end else if (r_ovf) begin
         w_final = r_op[1] ? 32'h0000_0000 : 32'h8000_0000;
      end
   end

`ifdef DIV_EARLY_OUT_EN
   // Override result computed straight from the live operands for the early-out path.
   logic [31:0] w_early_res;
   assign w_early_res = OP[1] ? (w_div0 ? DIVIDEND : 32'h0000_0000)
                              : (w_div0 ? 32'hFFFF_FFFF : 32'h8000_0000);
`endif

   // Control FSM, operand latching, iteration and result register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state   <= S_IDLE;
         r_cnt     <= 5'd0;
         r_op      <= 2'd0;
         r_quo     <= 32'h0;
         r_rem     <= 33'h0;
         r_dsr     <= 32'h0;
         r_dvd_raw <= 32'h0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_div0    <= 1'b0;
         r_ovf     <= 1'b0;
         r_result  <= 32'h0;
      end else if (w_accept) begin
         r_op      <= OP;
         r_quo     <= w_a_mag;
         r_rem     <= 33'h0;
         r_dsr     <= w_b_mag;
         r_dvd_raw <= DIVIDEND;
         r_neg_q   <= w_a_neg ^ w_b_neg;
         r_neg_r   <= w_a_neg;
         r_div0    <= w_div0;
         r_ovf     <= w_ovf;
         r_cnt     <= 5'd0;
`ifdef DIV_EARLY_OUT_EN
         if (w_div0 || w_ovf) begin
            r_state  <= S_FIN;
            r_result <= w_early_res;
         end else begin
            r_state  <= S_RUN;
         end
`else
         r_state   <= S_RUN;
`endif
      end else if (r_state == S_RUN) begin
         r_rem <= w_rem_nx;
         r_quo <= w_quo_nx;
         r_cnt <= r_cnt + 5'd1;
         if (r_cnt == 5'd31) begin
            r_state  <= S_FIN;
            r_result <= w_final;
         end
      end else begin
         r_state <= S_IDLE;
      end
   end

   assign BUSY   = (r_state == S_RUN);
   assign DONE   = (r_state == S_FIN);
   assign RESULT = r_result;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed-vector bench for div_unit with hand-computed results.
// Checks result values, DONE latency in edges from accept, BUSY cycle count, handshake and reset abort.
// Expected latency for special cases follows DIV_EARLY_OUT_EN when the bench is built with it.
module tb_div_unit;

   logic        CLK;
   logic        RESET;
   logic        START;
   logic [1:0]  OP;
   logic [31:0] DIVIDEND;
   logic [31:0] DIVISOR;
   logic        BUSY;
   logic        DONE;
   logic [31:0] RESULT;

   int checks   = 0;
   int failures = 0;

`ifdef DIV_EARLY_OUT_EN
   localparam int SP_LAT  = 1;
   localparam int SP_BUSY = 0;
`else
   localparam int SP_LAT  = 33;
   localparam int SP_BUSY = 32;
`endif

   div_unit dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .START    (START),
      .OP       (OP),
      .DIVIDEND (DIVIDEND),
      .DIVISOR  (DIVISOR),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .RESULT   (RESULT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Drive a request in the current (negedge) cycle, let it be accepted, then scramble inputs.
   task automatic issue_now(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      START    = 1'b1;
      OP       = op;
      DIVIDEND = a;
      DIVISOR  = b;
      @(posedge CLK);
      @(negedge CLK);
      START    = 1'b0;
      OP       = ~op;
      DIVIDEND = ~a;
      DIVISOR  = b ^ 32'h5A5A_0001;
   endtask

   task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge CLK);
      chk({tag, "_done_low_before"}, {31'd0, DONE}, 32'd0);
      issue_now(op, a, b);
   endtask

   // Called at the first negedge after accept (lat0=1); returns at the negedge where DONE is high.
   task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat,
                            input int exp_busy, input int lat0, input int busy0);
      int lat;
      int busy;
      lat  = lat0;
      busy = busy0;
      while (!DONE && lat < 200) begin
         if (BUSY) busy++;
         @(negedge CLK);
         lat++;
      end
      chk({tag, "_done_seen"}, {31'd0, DONE}, 32'd1);
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_busy_cycles"}, busy, exp_busy);
      chk({tag, "_busy_low_at_done"}, {31'd0, BUSY}, 32'd0);
      chk({tag, "_result"}, RESULT, exp_res);
   endtask

   initial begin
      int done_cnt;
      RESET    = 1'b1;
      START    = 1'b0;
      OP       = 2'b00;
      DIVIDEND = 32'h0;
      DIVISOR  = 32'h0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset_busy", {31'd0, BUSY}, 32'd0);
      chk("reset_done", {31'd0, DONE}, 32'd0);
      chk("reset_result", RESULT, 32'd0);
      RESET = 1'b0;

      // Basic signed/unsigned quotient and remainder
      issue("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
      wait_done("div_m7_2", 32'hFFFF_FFFD, 33, 32, 1, 0);
      issue("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
      wait_done("rem_m7_2", 32'hFFFF_FFFF, 33, 32, 1, 0);
      issue("remu_fff9_2", 2'b11, 32'hFFFF_FFF9, 32'd2);
      wait_done("remu_fff9_2", 32'h0000_0001, 33, 32, 1, 0);
      issue("divu_ffff_2", 2'b01, 32'hFFFF_FFFF, 32'd2);
      wait_done("divu_ffff_2", 32'h7FFF_FFFF, 33, 32, 1, 0);
      issue("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE);
      wait_done("div_7_m2", 32'hFFFF_FFFD, 33, 32, 1, 0);
      issue("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);
      wait_done("rem_7_m2", 32'h0000_0001, 33, 32, 1, 0);

      // Divide by zero
      issue("div_5_0", 2'b00, 32'd5, 32'd0);
      wait_done("div_5_0", 32'hFFFF_FFFF, SP_LAT, SP_BUSY, 1, 0);
      issue("rem_5_0", 2'b10, 32'd5, 32'd0);
      wait_done("rem_5_0", 32'h0000_0005, SP_LAT, SP_BUSY, 1, 0);
      issue("remu_8000_0", 2'b11, 32'h8000_0000, 32'd0);
      wait_done("remu_8000_0", 32'h8000_0000, SP_LAT, SP_BUSY, 1, 0);
      issue("div_m5_0", 2'b00, 32'hFFFF_FFFB, 32'd0);
      wait_done("div_m5_0", 32'hFFFF_FFFF, SP_LAT, SP_BUSY, 1, 0);

      // Signed overflow
      issue("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_ovf", 32'h8000_0000, SP_LAT, SP_BUSY, 1, 0);
      issue("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("rem_ovf", 32'h0000_0000, SP_LAT, SP_BUSY, 1, 0);

      // START during RUN is ignored: 100/3 completes with 33
      issue("ign_100_3", 2'b00, 32'd100, 32'd3);
      repeat (3) @(negedge CLK);
      START    = 1'b1;
      OP       = 2'b00;
      DIVIDEND = 32'd100;
      DIVISOR  = 32'd7;
      @(negedge CLK);
      START    = 1'b0;
      wait_done("ign_100_3", 32'h0000_0021, 33, 32, 5, 4);

      // START held during FIN: 100/7 accepted back-to-back
      issue_now(2'b00, 32'd100, 32'd7);
      wait_done("b2b_100_7", 32'd14, 33, 32, 1, 0);

      // Reset 10 cycles into RUN aborts with no DONE
      issue("rst_abort", 2'b01, 32'd1000, 32'd3);
      repeat (9) @(negedge CLK);
      chk("rst_busy_before", {31'd0, BUSY}, 32'd1);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      chk("rst_busy_after", {31'd0, BUSY}, 32'd0);
      chk("rst_result_after", RESULT, 32'd0);
      done_cnt = 0;
      repeat (40) begin
         if (DONE) done_cnt++;
         @(negedge CLK);
      end
      chk("rst_no_done", done_cnt, 0);

      issue("divu_9_3", 2'b01, 32'd9, 32'd3);
      wait_done("divu_9_3", 32'd3, 33, 32, 1, 0);
      @(negedge CLK);
      chk("divu_9_3_done_single", {31'd0, DONE}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
